// File: rtl/flow_sched_pkg.sv
// flow_sched_pkg: shared state encoding, default widths and command-record sizing for the flow scheduler
package flow_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_ISSUE} state_e;
  localparam int DEF_CREDIT_W = 32;
  localparam int DEF_FRAC_BITS = 16;
  localparam int DEF_SIZE_W = 11;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cmd_w(input int n, input int size_w);
    return size_w + id_w(n);
  endfunction
endpackage

// File: rtl/flow_rate_scheduler_rr_select.sv
// rr_select: combinational round-robin pick of the first eligible flow at or after rr_ptr
module rr_select
  import flow_sched_pkg::*;
#(
  parameter int N_FLOWS = 4,
  localparam int IDW = id_w(N_FLOWS)
) (
  input  logic [N_FLOWS-1:0] eligible,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     pick,
  output logic               any_valid
);
  // scan offsets from farthest to nearest so the nearest eligible index wins
  always_comb begin
    pick = '0;
    any_valid = |eligible;
    for (int k = N_FLOWS - 1; k >= 0; k--)
      if (eligible[(int'(rr_ptr) + k) % N_FLOWS]) pick = IDW'((int'(rr_ptr) + k) % N_FLOWS);
  end
endmodule

// File: rtl/flow_rate_scheduler.sv
// flow_rate_scheduler: token-bucket paced round-robin command issuer; FLOW_SCHED_STATS_EN adds per-flow issue counters
module flow_rate_scheduler
  import flow_sched_pkg::*;
#(
  parameter int N_FLOWS = 4,
  parameter int SIZE_W = DEF_SIZE_W,
  parameter int CREDIT_W = DEF_CREDIT_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int BURST = 2,
  localparam int IDW = id_w(N_FLOWS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [N_FLOWS-1:0]           flow_en,
  input  logic [N_FLOWS*CREDIT_W-1:0]  flow_inc,
  input  logic [N_FLOWS*SIZE_W-1:0]    flow_size,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [IDW-1:0]               cmd_flow_id,
  output logic [SIZE_W-1:0]            cmd_size,
  output logic [N_FLOWS*32-1:0]        pkt_count
);
  localparam int CMD_W = cmd_w(N_FLOWS, SIZE_W);
  localparam int XW = CREDIT_W + SIZE_W + 8;
  localparam logic [XW-1:0] MAX_C = XW'({CREDIT_W{1'b1}});
  state_e state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, pick;
  logic any_valid, sel;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [N_FLOWS-1:0] elig;
  assign sel = state_q == ST_SELECT && any_valid;
  assign cmd_valid = state_q == ST_ISSUE;
  assign cmd_flow_id = cmd_q[IDW-1:0];
  assign cmd_size = cmd_q[CMD_W-1 -: SIZE_W];
  rr_select #(.N_FLOWS(N_FLOWS)) u_rr (
    .eligible (elig),
    .rr_ptr   (rr_ptr_q),
    .pick     (pick),
    .any_valid(any_valid)
  );
  for (genvar f = 0; f < N_FLOWS; f++) begin : g_flow
    logic [SIZE_W-1:0] size;
    logic [XW-1:0] need, cap, sum;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic elig_q, elig_d;
    assign size = flow_size[f*SIZE_W +: SIZE_W];
    assign elig[f] = elig_q;
    // refill, debit on grant, clamp to burst cap and accumulator range; eligibility from the current bucket
    always_comb begin
      need = XW'(size) << FRAC_BITS;
      cap = need * XW'(BURST);
      sum = XW'(credit_q) + XW'(flow_inc[f*CREDIT_W +: CREDIT_W]);
      sum = (sel && pick == IDW'(f)) ? (sum < need ? '0 : sum - need) : sum;
      sum = sum > cap ? cap : sum;
      sum = sum > MAX_C ? MAX_C : sum;
      credit_d = flow_en[f] ? CREDIT_W'(sum) : '0;
      elig_d = flow_en[f] && size != '0 && XW'(credit_q) >= need;
    end
    // per-flow bucket and eligibility registers
    always_ff @(posedge clk) begin
      if (rst) begin
        credit_q <= '0;
        elig_q <= 1'b0;
      end else begin
        credit_q <= credit_d;
        elig_q <= elig_d;
      end
    end
  end
  // grant FSM: wait for an eligible flow, latch the round-robin pick, hold the command until accepted
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    cmd_d = cmd_q;
    case (state_q)
      ST_IDLE: state_d = (enable && |elig) ? ST_SELECT : ST_IDLE;
      ST_SELECT: begin
        state_d = any_valid ? ST_ISSUE : ST_IDLE;
        cmd_d = any_valid ? {flow_size[int'(pick)*SIZE_W +: SIZE_W], pick} : cmd_q;
        rr_ptr_d = !any_valid ? rr_ptr_q : (int'(pick) == N_FLOWS - 1 ? '0 : pick + 1'b1);
      end
      ST_ISSUE: state_d = cmd_ready ? ST_IDLE : ST_ISSUE;
      default: state_d = ST_IDLE;
    endcase
  end
  // FSM, round-robin pointer and command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_ptr_q <= '0;
      cmd_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cmd_q <= cmd_d;
    end
  end
`ifdef FLOW_SCHED_STATS_EN
  for (genvar f = 0; f < N_FLOWS; f++) begin : g_cnt
    logic [31:0] cnt_q, cnt_d;
    assign pkt_count[f*32 +: 32] = cnt_q;
    // count accepted commands for this flow, wrapping at 2^32
    always_comb cnt_d = (cmd_valid && cmd_ready && cmd_flow_id == IDW'(f)) ? cnt_q + 32'd1 : cnt_q;
    // issued-packet counter register
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
  end
`else
  assign pkt_count = '0;
`endif
endmodule

// File: tb/tb_flow_rate_scheduler.sv
// tb_flow_rate_scheduler: random and directed stimulus checked against a behavioural token-bucket model
module tb_flow_rate_scheduler;
  localparam int N = 4, SW = 11, CW = 32, FB = 16, BURST = 2;
  logic clk = 0, rst = 1, enable = 0, cmd_ready = 0;
  logic [N-1:0] flow_en = '0;
  logic [N*CW-1:0] flow_inc = '0;
  logic [N*SW-1:0] flow_size = '0;
  logic cmd_valid;
  logic [1:0] cmd_flow_id;
  logic [SW-1:0] cmd_size;
  logic [N*32-1:0] pkt_count;
  int n_vec = 0, n_err = 0;
  int hs_cnt[N];
  bit chk_on = 0;
  longint m_cred[N], m_cnt[N];
  bit m_elig[N];
  int m_phase = 0, m_ptr = 0, m_id = 0, m_sz = 0;

  always #5 clk = ~clk;

  flow_rate_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .flow_en(flow_en), .flow_inc(flow_inc),
    .flow_size(flow_size), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_flow_id(cmd_flow_id), .cmd_size(cmd_size), .pkt_count(pkt_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_flow(input int f, input logic en, input logic [CW-1:0] inc, input logic [SW-1:0] sz);
    flow_en[f] = en;
    flow_inc[f*CW +: CW] = inc;
    flow_size[f*SW +: SW] = sz;
  endtask

  task automatic wait_valid(input int lim);
    for (int i = 0; i < lim && !cmd_valid; i++) cyc(1);
    check("wait_valid", cmd_valid, 1);
  endtask

  function automatic int total_hs();
    int s = 0;
    for (int f = 0; f < N; f++) s += hs_cnt[f];
    return s;
  endfunction

  // reference model: token buckets as plain integers, grant phase 0=idle 1=select 2=issue
  always @(posedge clk) begin : model
    int pick, nph;
    longint sum, need, cap;
    bit any;
    if (rst) begin
      for (int f = 0; f < N; f++) begin
        m_cred[f] = 0; m_elig[f] = 0; m_cnt[f] = 0;
      end
      m_phase = 0; m_ptr = 0; m_id = 0; m_sz = 0;
    end else begin
      pick = -1;
      any = 0;
      for (int f = 0; f < N; f++) any |= m_elig[f];
      if (m_phase == 2) begin
`ifdef FLOW_SCHED_STATS_EN
        if (cmd_ready) m_cnt[m_id] = (m_cnt[m_id] + 1) & 64'hFFFF_FFFF;
`endif
        nph = cmd_ready ? 0 : 2;
      end else if (m_phase == 1) begin
        for (int k = 0; k < N; k++)
          if (pick < 0 && m_elig[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        nph = pick >= 0 ? 2 : 0;
        if (pick >= 0) begin
          m_id = pick;
          m_sz = int'(flow_size[pick*SW +: SW]);
          m_ptr = (pick + 1) % N;
        end
      end else nph = (enable && any) ? 1 : 0;
      for (int f = 0; f < N; f++) begin
        need = longint'(flow_size[f*SW +: SW]) * 65536;
        cap = BURST * need;
        m_elig[f] = flow_en[f] && need != 0 && m_cred[f] >= need;
        sum = m_cred[f] + longint'(flow_inc[f*CW +: CW]);
        if (f == pick) sum = sum < need ? 0 : sum - need;
        if (sum > cap) sum = cap;
        if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
        m_cred[f] = flow_en[f] ? sum : 0;
      end
      m_phase = nph;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cmd_valid", cmd_valid, m_phase == 2);
      if (m_phase == 2) begin
        check("cmd_flow_id", cmd_flow_id, m_id);
        check("cmd_size", cmd_size, m_sz);
      end
      for (int f = 0; f < N; f++) check("pkt_count", pkt_count[f*32 +: 32], m_cnt[f]);
      if (cmd_valid && cmd_ready) hs_cnt[cmd_flow_id]++;
    end
  end

  initial begin
    int id0, sz0, h, h3, c0, c1, n;
    cyc(2);
    chk_on = 1;
    check("rst_valid", cmd_valid, 0);
    check("rst_id", cmd_flow_id, 0);
    check("rst_size", cmd_size, 0);
    rst = 0;
    // equal flows, always ready: strict rotation
    for (int f = 0; f < N; f++) set_flow(f, 1, 32'h10000, 4);
    enable = 1;
    cmd_ready = 1;
    cyc(80);
    // backpressure: command held stable, exactly one accepted on release
    cmd_ready = 0;
    wait_valid(50);
    id0 = cmd_flow_id;
    sz0 = cmd_size;
    cyc(50);
    check("hold_valid", cmd_valid, 1);
    check("hold_id", cmd_flow_id, id0);
    check("hold_size", cmd_size, sz0);
    h = total_hs();
    cmd_ready = 1;
    cyc(1);
    cmd_ready = 0;
    cyc(5);
    check("release_one", total_hs() - h, 1);
    // reset during issue drops the command; first grant afterwards is flow 0
    wait_valid(50);
    rst = 1;
    cyc(1);
    check("rst_drop", cmd_valid, 0);
    rst = 0;
    cmd_ready = 1;
    wait_valid(50);
    check("rst_first_id", cmd_flow_id, 0);
    // zero size never becomes eligible even with maximal refill
    set_flow(3, 1, 32'hFFFF_FFFF, 0);
    h3 = hs_cnt[3];
    cyc(300);
    check("size0_never", hs_cnt[3] - h3, 0);
    // random configuration segments
    for (int s = 0; s < 40; s++) begin
      for (int f = 0; f < N; f++) begin
        case ($urandom % 4)
          0: flow_inc[f*CW +: CW] = 32'hFFFF_FFFF;
          1: flow_inc[f*CW +: CW] = 0;
          default: flow_inc[f*CW +: CW] = $urandom_range(0, 32'h30000);
        endcase
        flow_en[f] = ($urandom % 4) != 0;
        flow_size[f*SW +: SW] = ($urandom % 6 == 0) ? 0 :
                                (($urandom % 5 == 0) ? SW'($urandom_range(1, 2047)) : SW'($urandom_range(1, 40)));
      end
      enable = ($urandom % 5) != 0;
      for (int c = 0; c < 60; c++) begin
        cmd_ready = ($urandom % 4) != 0;
        rst = ($urandom % 200) == 0;
        if ($urandom % 30 == 0) flow_en[$urandom % N] ^= 1'b1;
        cyc(1);
      end
      rst = 0;
    end
    // long-run rate ratio 2:1
    rst = 1;
    cyc(1);
    rst = 0;
    set_flow(0, 1, 32'h8000, 64);
    set_flow(1, 1, 32'h4000, 64);
    set_flow(2, 0, 0, 0);
    set_flow(3, 0, 0, 0);
    enable = 1;
    cmd_ready = 1;
    for (int f = 0; f < N; f++) hs_cnt[f] = 0;
    cyc(20000);
    c0 = hs_cnt[0];
    c1 = hs_cnt[1];
    check("ratio_2to1", (c0 - 2 * c1 <= 2) && (2 * c1 - c0 <= 2), 1);
    check("ratio_active", c1 > 50, 1);
    // ten handshakes on flow 2 only
    rst = 1;
    cyc(1);
    rst = 0;
    for (int f = 0; f < N; f++) set_flow(f, 0, 0, 0);
    set_flow(2, 1, 32'h10000, 4);
    n = 0;
    for (int g = 0; g < 1000 && n < 10; g++) begin
      if (cmd_valid) n++;
      cyc(1);
    end
    cmd_ready = 0;
    flow_en = '0;
    cyc(2);
    check("hs_count10", n, 10);
`ifdef FLOW_SCHED_STATS_EN
    check("stats_flow2", pkt_count[2*32 +: 32], 10);
`else
    check("stats_flow2", pkt_count[2*32 +: 32], 0);
`endif
    check("stats_flow0", pkt_count[0 +: 32], 0);
    check("stats_flow1", pkt_count[32 +: 32], 0);
    check("stats_flow3", pkt_count[96 +: 32], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
